// File: rtl/vec_inst_queue_if.sv
// rtl/vec_inst_queue_if.sv - scalar-to-vector instruction queue handshake bundle
`ifndef XLEN
`define XLEN 32
`endif

interface vec_inst_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              inst_valid;
  logic [`XLEN-1:0]  inst_in;
  logic [`XLEN-1:0]  rs1_in;
  logic [`XLEN-1:0]  rs2_in;
  logic              inst_ready;
  logic              flush;
  logic [`XLEN-1:0]  vec_inst;
  logic [`XLEN-1:0]  rs1_data;
  logic [`XLEN-1:0]  rs2_data;
  logic              vec_inst_valid;
  logic              vec_pro_ready;
  logic [CW-1:0]     count;
  logic              illegal_inst;

  modport master (
    output inst_valid, inst_in, rs1_in, rs2_in, flush, vec_pro_ready,
    input  inst_ready, vec_inst, rs1_data, rs2_data, vec_inst_valid, count, illegal_inst
  );

  modport slave (
    input  inst_valid, inst_in, rs1_in, rs2_in, flush, vec_pro_ready,
    output inst_ready, vec_inst, rs1_data, rs2_data, vec_inst_valid, count, illegal_inst
  );
endinterface

// File: rtl/vec_inst_queue.sv
// rtl/vec_inst_queue.sv - FIFO of vector instructions plus scalar operands
// Optional zero-latency bypass when empty: define VEC_INST_QUEUE_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module vec_inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  vec_inst_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [`XLEN-1:0] inst_mem [DEPTH];
  logic [`XLEN-1:0] rs1_mem  [DEPTH];
  logic [`XLEN-1:0] rs2_mem  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          illegal_q;

  logic opcode_legal;
  logic full;
  logic empty;
  logic ready;
  logic offer;
  logic bypass;
  logic push;
  logic pop;

  assign opcode_legal = (q.inst_in[6:0] == 7'h57) ||
                        (q.inst_in[6:0] == 7'h07) ||
                        (q.inst_in[6:0] == 7'h27);

  // Readiness looks only at the registered count, so a pop never frees a slot
  // for a same-cycle push.
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign ready  = !full && !q.flush && !reset;
  assign offer  = q.inst_valid && ready;

`ifdef VEC_INST_QUEUE_BYPASS_EN
  assign bypass = offer && opcode_legal && empty && q.vec_pro_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = offer && opcode_legal && !bypass;
  assign pop  = !empty && q.vec_pro_ready;

  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      illegal_q <= offer && !opcode_legal;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      inst_mem[wr_ptr] <= q.inst_in;
      rs1_mem[wr_ptr]  <= q.rs1_in;
      rs2_mem[wr_ptr]  <= q.rs2_in;
    end
  end

  always_comb begin
    q.vec_inst       = '0;
    q.rs1_data       = '0;
    q.rs2_data       = '0;
    q.vec_inst_valid = 1'b0;
    if (bypass) begin
      q.vec_inst       = q.inst_in;
      q.rs1_data       = q.rs1_in;
      q.rs2_data       = q.rs2_in;
      q.vec_inst_valid = 1'b1;
    end else if (!empty) begin
      q.vec_inst       = inst_mem[rd_ptr];
      q.rs1_data       = rs1_mem[rd_ptr];
      q.rs2_data       = rs2_mem[rd_ptr];
      q.vec_inst_valid = 1'b1;
    end
  end

  assign q.inst_ready   = ready;
  assign q.count        = cnt;
  assign q.illegal_inst = illegal_q;
endmodule

// File: doc/vec_inst_queue.md
VEC_INST_QUEUE -- requirements
Module: vec_inst_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of instruction entries (power of two, >=2).
REQ-002 SHALL take data width from the `XLEN define in the vector processor defines.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: inst_valid  input  1  scalar processor offers an instruction.
REQ-006 SHALL have port: inst_in  input  XLEN  offered instruction word.
REQ-007 SHALL have port: rs1_in / rs2_in  input  XLEN each  scalar operands travelling with the instruction.
REQ-008 SHALL have port: inst_ready  output  1  queue accepts the offer this cycle.
REQ-009 SHALL have port: flush  input  1  discard all queued entries.
REQ-010 SHALL have port: vec_inst  output  XLEN  head instruction, to the vector controller.
REQ-011 SHALL have port: rs1_data / rs2_data  output  XLEN each  head operands, to the vector decode.
REQ-012 SHALL have port: vec_inst_valid  output  1  head entry present.
REQ-013 SHALL have port: vec_pro_ready  input  1  vector processor consumes the head this cycle.
REQ-014 SHALL have port: count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have port: illegal_inst  output  1  one-cycle pulse, rejected opcode.

Function
REQ-016 Push SHALL occur when inst_valid & inst_ready & legal opcode; legal = inst_in[6:0] in {7'h57 V_ARITH, 7'h07 V_LOAD, 7'h27 V_STORE}.
REQ-017 inst_ready SHALL equal (count != DEPTH) & !flush, from registered count only; a pop in the same cycle SHALL NOT free a slot for a push while full.
REQ-018 An accepted illegal opcode SHALL not be written; illegal_inst SHALL be 1 in the following cycle only.
REQ-019 Pop SHALL occur when vec_inst_valid & vec_pro_ready; the head advances on that edge.
REQ-020 vec_inst_valid SHALL equal (count != 0); when 0, vec_inst, rs1_data and rs2_data SHALL be driven 0.
REQ-021 Write and read pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, advance both pointers.
REQ-023 Order SHALL be strict FIFO; latency push-to-valid SHALL be one cycle (non-bypass).
REQ-024 flush SHALL, at the next edge, zero pointers and count and clear illegal_inst; push and pop in the flush cycle SHALL be ignored.
REQ-025 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-026 On reset: pointers 0, count 0, illegal_inst 0, vec_inst_valid 0, data outputs 0, inst_ready 0 during the reset cycle.
REQ-027 reset SHALL take priority over flush, push and pop; entry storage need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all entries; first push after release SHALL appear as head.

Configuration
REQ-029 Macro VEC_INST_QUEUE_BYPASS_EN SHALL control zero-latency bypass.
REQ-030 With the macro defined: when count==0, inst_valid, legal opcode and vec_pro_ready, outputs SHALL show inst_in/rs1_in/rs2_in combinationally with vec_inst_valid=1; the entry SHALL NOT be written; count stays 0.
REQ-031 With the macro defined and count==0 but vec_pro_ready=0, the instruction SHALL be pushed normally.
REQ-032 Without the macro, vec_inst_valid SHALL depend only on registered count (REQ-023).

Verification
REQ-033 Reset, push 0x00007057 (vsetvli) with rs1=5 -> next cycle vec_inst=0x00007057, rs1_data=5, count=1.
REQ-034 vec_pro_ready=0, push 5 legal insts -> 4 accepted, inst_ready=0 on 5th, count=4; then pop 4 -> same order, count=0, outputs 0.
REQ-035 Full queue, push and pop same cycle -> push refused, count=3 next cycle.
REQ-036 Push 0x00000033 (opcode 0x33) -> not queued, illegal_inst=1 for exactly one cycle, count unchanged.
REQ-037 count=3 with flush=1 and inst_valid=1 -> next cycle count=0, vec_inst_valid=0; reset mid-stream likewise.
REQ-038 Bypass build: empty, vec_pro_ready=1, push 0x02008407 -> vec_inst=0x02008407 same cycle, count stays 0; non-bypass build -> appears one cycle later.
